// File: rtl/readout_pkg.sv
// Shared definitions for the sample-RAM readout path: state encoding, header bytes
// and the default RAM geometry that the acquisition side also uses.
package readout_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    localparam logic [7:0] HDR_BYTE0 = 8'hA5;
    localparam logic [7:0] HDR_BYTE1 = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SEND,
        DONE,
        HDR0,
        HDR1
    } state_e;

endpackage

// File: rtl/readout_if.sv
// RAM read port plus the byte-stream handshake toward the sink.
// The master side is the readout engine; the slave side is RAM + sink.
interface readout_if
    import readout_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output rd_addr, rd_en, tx_data, tx_valid,
        input  rd_data, tx_ready
    );

    modport slave (
        input  rd_addr, rd_en, tx_data, tx_valid,
        output rd_data, tx_ready
    );

endinterface

// File: rtl/readout_rd_addr_counter.sv
// Read-side RAM address counter; synchronous clear wins over count enable.
// Mirrors the write-side address counter of the acquisition block.
module rd_addr_counter
    import readout_pkg::*;
#(
    parameter int W = ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cnt_en_i,
    input  logic         sclr_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (sclr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/readout.sv
// Streams the whole sample RAM, address 0 upward, to a valid/ready byte sink.
// Define READOUT_HEADER_EN to prefix each frame with the bytes 0xA5, 0x5A.
module readout
    import readout_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     grant_rd,
    output logic     done_rd,
    output logic     busy_rd,
    readout_if.master bus
);

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] tx_data_q;
    logic [DATA_W-1:0] tx_data_d;
    logic              cnt_en;
    logic              sclr;
    logic [ADDR_W-1:0] addr;

    rd_addr_counter #(
        .W(ADDR_W)
    ) u_addr (
        .clk      (clk),
        .rst      (rst),
        .cnt_en_i (cnt_en),
        .sclr_i   (sclr),
        .q_o      (addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Termination is an all-ones compare on the current address, so the counter never wraps.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        cnt_en    = 1'b0;
        sclr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_rd) begin
                    sclr = 1'b1;
`ifdef READOUT_HEADER_EN
                    state_d   = HDR0;
                    tx_data_d = DATA_W'(HDR_BYTE0);
`else
                    state_d   = FETCH;
`endif
                end
            end
`ifdef READOUT_HEADER_EN
            HDR0: begin
                if (bus.tx_ready) begin
                    state_d   = HDR1;
                    tx_data_d = DATA_W'(HDR_BYTE1);
                end
            end
            HDR1: begin
                if (bus.tx_ready) begin
                    state_d = FETCH;
                end
            end
`endif
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                tx_data_d = bus.rd_data;
                state_d   = SEND;
            end
            SEND: begin
                if (bus.tx_ready) begin
                    if (addr == '1) begin
                        state_d = DONE;
                    end else begin
                        cnt_en  = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                sclr    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rd_addr = addr;
    assign bus.rd_en   = (state_q == FETCH);
    assign bus.tx_data = tx_data_q;
`ifdef READOUT_HEADER_EN
    assign bus.tx_valid = (state_q == SEND) || (state_q == HDR0) || (state_q == HDR1);
`else
    assign bus.tx_valid = (state_q == SEND);
`endif
    assign done_rd = (state_q == DONE);
    assign busy_rd = (state_q != IDLE);

endmodule

// File: tb/tb_readout.sv
// Self-checking bench for readout: a registered RAM model feeds the DUT, a monitor records
// accepted bytes and event cycles, and each scenario compares them with a frame-level model.
module tb_readout;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int N  = 1 << AW;
`ifdef READOUT_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int FRAME_CYC = 3 * N + 2 + 2 * HDR;

    logic clk = 1'b0;
    logic rst;
    logic grant_rd;
    logic done_rd;
    logic busy_rd;

    readout_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    readout #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .grant_rd (grant_rd),
        .done_rd  (done_rd),
        .busy_rd  (busy_rd),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [N];

    // Registered-read RAM: data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data <= mem[bus.rd_addr];
        end
    end

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    logic [7:0] acc_q [$];
    logic [7:0] exp_q [$];
    int         done_q [$];
    int         grant_q [$];
    int         vrise_q [$];
    int         erise_q [$];
    int         rden_cnt [N];
    int         overlap;
    int         stab_err;
    int         stall_cnt;
    logic       prev_stall;
    logic       prev_valid;
    logic       prev_rden;
    logic [7:0] prev_data;

    // Recording-only monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
            prev_rden  = 1'b0;
        end else begin
            if (bus.tx_valid && bus.tx_ready) acc_q.push_back(bus.tx_data);
            if (bus.tx_valid && !bus.tx_ready) stall_cnt++;
            if (prev_stall && (!bus.tx_valid || bus.tx_data !== prev_data)) stab_err++;
            if (bus.rd_en) begin
                rden_cnt[bus.rd_addr]++;
                if (bus.tx_valid) overlap++;
            end
            if (done_rd) done_q.push_back(cyc);
            if (grant_rd && !busy_rd) grant_q.push_back(cyc);
            if (bus.tx_valid && !prev_valid) vrise_q.push_back(cyc);
            if (bus.rd_en && !prev_rden) erise_q.push_back(cyc);
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
            prev_valid = bus.tx_valid;
            prev_rden  = bus.rd_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        acc_q.delete();
        done_q.delete();
        grant_q.delete();
        vrise_q.delete();
        erise_q.delete();
        foreach (rden_cnt[i]) rden_cnt[i] = 0;
        overlap   = 0;
        stab_err  = 0;
        stall_cnt = 0;
    endtask

    // Reference frame(s): optional header, then every RAM byte in address order.
    task automatic build_exp(input int frames);
        exp_q.delete();
        for (int f = 0; f < frames; f++) begin
            if (HDR != 0) begin
                exp_q.push_back(8'hA5);
                exp_q.push_back(8'h5A);
            end
            for (int i = 0; i < N; i++) exp_q.push_back(mem[i]);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        grant_rd     = 1'b0;
        bus.tx_ready = 1'b0;
        repeat (3) tick();
        vectors++;
        if (busy_rd !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %b expected 0", busy_rd); end
        vectors++;
        if (done_rd !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_done: got %b expected 0", done_rd); end
        vectors++;
        if (bus.tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_valid: got %b expected 0", bus.tx_valid); end
        vectors++;
        if (bus.rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rden: got %b expected 0", bus.rd_en); end
        vectors++;
        if (bus.rd_addr !== 10'h000) begin miscompares++; $display("[TB] FAIL rst_addr: got %h expected 000", bus.rd_addr); end
        vectors++;
        if (bus.tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_data: got %h expected 00", bus.tx_data); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_ready();
        int bad, first, g, missing;
        clear_mon();
        build_exp(1);
        bus.tx_ready = 1'b1;
        grant_rd     = 1'b1;
        tick();
        grant_rd = 1'b0;
        for (int i = 0; i < FRAME_CYC + 100 && done_q.size() == 0; i++) tick();
        repeat (5) tick();
        vectors++;
        if (done_q.size() != 1) begin miscompares++; $display("[TB] FAIL full_done_count: got %0d expected 1", done_q.size()); end
        g = (grant_q.size() > 0) ? grant_q[0] : -100000;
        vectors++;
        if (((done_q.size() > 0) ? done_q[0] - g + 1 : -1) != FRAME_CYC) begin
            miscompares++;
            $display("[TB] FAIL full_latency: got %0d expected %0d", (done_q.size() > 0) ? done_q[0] - g + 1 : -1, FRAME_CYC);
        end
        vectors++;
        if (((vrise_q.size() > 0) ? vrise_q[0] - g : -1) != ((HDR != 0) ? 1 : 3)) begin
            miscompares++;
            $display("[TB] FAIL first_valid_lat: got %0d expected %0d", (vrise_q.size() > 0) ? vrise_q[0] - g : -1, (HDR != 0) ? 1 : 3);
        end
        vectors++;
        if (((erise_q.size() > 0) ? erise_q[0] - g : -1) != ((HDR != 0) ? 3 : 1)) begin
            miscompares++;
            $display("[TB] FAIL first_rden_lat: got %0d expected %0d", (erise_q.size() > 0) ? erise_q[0] - g : -1, (HDR != 0) ? 3 : 1);
        end
        bad = 0; first = -1;
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
            if (acc_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
        vectors++;
        if (acc_q.size() != exp_q.size() || bad != 0) begin
            miscompares++;
            $display("[TB] FAIL full_bytes: got %0d bytes (%0d wrong, first at %0d) expected %0d bytes", acc_q.size(), bad, first, exp_q.size());
        end
        missing = 0;
        foreach (rden_cnt[i]) if (rden_cnt[i] != 1) missing++;
        vectors++;
        if (missing != 0) begin miscompares++; $display("[TB] FAIL full_rden_once: got %0d addresses off, expected 0", missing); end
        vectors++;
        if (overlap != 0) begin miscompares++; $display("[TB] FAIL full_rden_vs_valid: got %0d overlaps expected 0", overlap); end
        vectors++;
        if (busy_rd !== 1'b0) begin miscompares++; $display("[TB] FAIL full_busy_after: got %b expected 0", busy_rd); end
    endtask

    task automatic test_random_ready();
        int bad, first, g;
        clear_mon();
        build_exp(1);
        grant_rd = 1'b1;
        for (int i = 0; i < 6 * FRAME_CYC && done_q.size() == 0; i++) begin
            bus.tx_ready = 1'($urandom_range(0, 1));
            tick();
            grant_rd = 1'b0;
        end
        bus.tx_ready = 1'b1;
        repeat (5) tick();
        vectors++;
        if (done_q.size() != 1) begin miscompares++; $display("[TB] FAIL rand_done_count: got %0d expected 1", done_q.size()); end
        bad = 0; first = -1;
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
            if (acc_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
        vectors++;
        if (acc_q.size() != exp_q.size() || bad != 0) begin
            miscompares++;
            $display("[TB] FAIL rand_bytes: got %0d bytes (%0d wrong, first at %0d) expected %0d bytes", acc_q.size(), bad, first, exp_q.size());
        end
        vectors++;
        if (stab_err != 0) begin miscompares++; $display("[TB] FAIL rand_stable: got %0d changes under stall expected 0", stab_err); end
        vectors++;
        if (overlap != 0) begin miscompares++; $display("[TB] FAIL rand_rden_vs_valid: got %0d overlaps expected 0", overlap); end
        g = (grant_q.size() > 0) ? grant_q[0] : -100000;
        vectors++;
        if (((done_q.size() > 0) ? done_q[0] - g + 1 : -1) != FRAME_CYC + stall_cnt) begin
            miscompares++;
            $display("[TB] FAIL rand_latency: got %0d expected %0d", (done_q.size() > 0) ? done_q[0] - g + 1 : -1, FRAME_CYC + stall_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int bad, first;
        clear_mon();
        bus.tx_ready = 1'b1;
        grant_rd     = 1'b1;
        tick();
        grant_rd = 1'b0;
        for (int i = 0; i < 3 * FRAME_CYC && !(bus.tx_valid && bus.rd_addr == 10'h123); i++) begin
            bus.tx_ready = (bus.rd_addr != 10'h123);
            tick();
        end
        vectors++;
        if (!(bus.tx_valid === 1'b1 && bus.rd_addr === 10'h123)) begin
            miscompares++;
            $display("[TB] FAIL mid_reach_send: got valid=%b addr=%h expected valid=1 addr=123", bus.tx_valid, bus.rd_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_valid: got %b expected 0", bus.tx_valid); end
        vectors++;
        if (bus.rd_addr !== 10'h000) begin miscompares++; $display("[TB] FAIL mid_addr: got %h expected 000", bus.rd_addr); end
        vectors++;
        if (busy_rd !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy: got %b expected 0", busy_rd); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();
        clear_mon();
        build_exp(1);
        bus.tx_ready = 1'b1;
        grant_rd     = 1'b1;
        tick();
        grant_rd = 1'b0;
        for (int i = 0; i < FRAME_CYC + 100 && done_q.size() == 0; i++) tick();
        repeat (3) tick();
        vectors++;
        if (done_q.size() != 1) begin miscompares++; $display("[TB] FAIL restart_done_count: got %0d expected 1", done_q.size()); end
        bad = 0; first = -1;
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
            if (acc_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
        vectors++;
        if (acc_q.size() != exp_q.size() || bad != 0) begin
            miscompares++;
            $display("[TB] FAIL restart_bytes: got %0d bytes (%0d wrong, first at %0d) expected %0d bytes", acc_q.size(), bad, first, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int bad, first, missing, second_en;
        foreach (mem[i]) mem[i] = 8'($urandom);
        clear_mon();
        build_exp(2);
        bus.tx_ready = 1'b1;
        grant_rd     = 1'b1;
        for (int i = 0; i < 3 * FRAME_CYC && done_q.size() < 2; i++) tick();
        grant_rd = 1'b0;
        repeat (10) tick();
        vectors++;
        if (done_q.size() != 2) begin miscompares++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_q.size()); end
        vectors++;
        if (((done_q.size() > 1) ? done_q[1] - done_q[0] : -1) != FRAME_CYC) begin
            miscompares++;
            $display("[TB] FAIL b2b_period: got %0d expected %0d", (done_q.size() > 1) ? done_q[1] - done_q[0] : -1, FRAME_CYC);
        end
        second_en = -1;
        if (done_q.size() > 0)
            foreach (erise_q[i]) if (second_en < 0 && erise_q[i] > done_q[0]) second_en = erise_q[i] - done_q[0];
        vectors++;
        if (second_en != 2 + 2 * HDR) begin miscompares++; $display("[TB] FAIL b2b_rden_gap: got %0d expected %0d", second_en, 2 + 2 * HDR); end
        bad = 0; first = -1;
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
            if (acc_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
        vectors++;
        if (acc_q.size() != exp_q.size() || bad != 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_bytes: got %0d bytes (%0d wrong, first at %0d) expected %0d bytes", acc_q.size(), bad, first, exp_q.size());
        end
        missing = 0;
        foreach (rden_cnt[i]) if (rden_cnt[i] != 2) missing++;
        vectors++;
        if (missing != 0) begin miscompares++; $display("[TB] FAIL b2b_rden_twice: got %0d addresses off, expected 0", missing); end
        vectors++;
        if (busy_rd !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_busy_after: got %b expected 0", busy_rd); end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'(i);
        clear_mon();
        test_reset();
        test_full_ready();
        test_random_ready();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
